// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq -- multi-cycle 32-bit divider sequencer for the EX stage.
//
// Runs DIV (signed) / DIVU (unsigned) as a 32-iteration restoring divide. One
// quotient bit is produced per cycle, and the pipeline is stalled while the
// divide is busy. On completion a single-cycle write of {remainder, quotient}
// is issued toward the HI/LO register pair. A flush (annul) aborts a pending
// or running division without producing a write.
//
// Ports
//   clk          in   system clock, all state updates on the rising edge
//   rst          in   synchronous active-high reset
//   start_i      in   division request, held by EX until ready_o
//   annul_i      in   pipeline flush, aborts the current/pending division
//   signed_i     in   1 = DIV (two's complement), 0 = DIVU
//   opdata1_i    in   dividend, sampled only on the accepting cycle
//   opdata2_i    in   divisor, sampled only on the accepting cycle
//   stall_req_o  out  combinational stall request to the pipeline controller
//   ready_o      out  registered, one-cycle result-valid pulse
//   hilo_we_o    out  registered HI/LO write strobe, identical to ready_o
//   hi_o         out  registered remainder, held between operations
//   lo_o         out  registered quotient, held between operations
// -----------------------------------------------------------------------------
module div_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        annul_i,
   input  logic        signed_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   output logic        stall_req_o,
   output logic        ready_o,
   output logic        hilo_we_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   localparam int unsigned RegBus       = 32;
   localparam int unsigned DoubleRegBus = 64;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BYZERO,
      S_RUN,
      S_DONE
   } state_t;

   state_t                  r_state;
   state_t                  w_state_next;

   logic [5:0]              r_cnt;        // completed iterations, 0..32
   logic [DoubleRegBus:0]   r_work;       // {rem[32:0], quo[31:0]}
   logic [RegBus-1:0]       r_divisor;    // |divisor|
   logic                    r_neg_quo;    // operand signs differ (signed only)
   logic                    r_neg_rem;    // dividend negative (signed only)
   logic                    r_ready;
   logic                    r_hilo_we;
   logic [RegBus-1:0]       r_hi;
   logic [RegBus-1:0]       r_lo;

   logic [RegBus-1:0]       w_abs1;
   logic [RegBus-1:0]       w_abs2;
   logic [DoubleRegBus:0]   w_shifted;
   logic [RegBus:0]         w_trial;
   logic [DoubleRegBus:0]   w_work_next;
   logic [RegBus-1:0]       w_quo;
   logic [RegBus-1:0]       w_rem;
   logic [RegBus-1:0]       w_lo_fix;
   logic [RegBus-1:0]       w_hi_fix;

   // Magnitudes are only taken for DIV; DIVU operands pass straight through.
   // The most negative dividend maps onto itself, which is exactly 2^31 as an
   // unsigned magnitude, so 0x80000000 / -1 needs no special handling.
   assign w_abs1 = (signed_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
   assign w_abs2 = (signed_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

   // One restoring step. After the shift the partial remainder is below
   // 2*divisor, so bit 32 of the 33-bit trial difference is a reliable
   // borrow: set means "restore".
   assign w_shifted   = r_work << 1;
   assign w_trial     = w_shifted[DoubleRegBus:RegBus] - {1'b0, r_divisor};
   assign w_work_next = w_trial[RegBus] ? w_shifted
                                        : {w_trial, w_shifted[RegBus-1:1], 1'b1};

   assign w_quo    = w_work_next[RegBus-1:0];
   assign w_rem    = w_work_next[DoubleRegBus-1:RegBus];
   assign w_lo_fix = r_neg_quo ? (~w_quo + 32'd1) : w_quo;
   assign w_hi_fix = r_neg_rem ? (~w_rem + 32'd1) : w_rem;

   // NOTE: every output of this block gets a default before the case so that
   // no path leaves a signal unassigned, which would infer a latch.
   always_comb begin
      w_state_next = r_state;
      stall_req_o  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start_i && !annul_i) begin
               stall_req_o  = 1'b1;
               w_state_next = (opdata2_i == '0) ? S_BYZERO : S_RUN;
            end
         end
         S_BYZERO: begin
            stall_req_o  = 1'b1;
            w_state_next = annul_i ? S_IDLE : S_DONE;
         end
         S_RUN: begin
            if (annul_i) begin
               w_state_next = S_IDLE;
            end else begin
               stall_req_o = 1'b1;
               if (r_cnt == 6'd31) begin
                  w_state_next = S_DONE;
               end
            end
         end
         S_DONE: begin
            // The write has already been issued; annul is irrelevant here.
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // NOTE: sequential state is assigned with non-blocking (<=) only, so every
   // flop samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= '0;
         r_work    <= '0;
         r_divisor <= '0;
         r_neg_quo <= 1'b0;
         r_neg_rem <= 1'b0;
         r_ready   <= 1'b0;
         r_hilo_we <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
      end else begin
         // The result strobe is a single-cycle pulse coinciding with DONE.
         r_ready   <= 1'b0;
         r_hilo_we <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_state_next == S_RUN) begin
                  r_work    <= {33'd0, w_abs1};
                  r_divisor <= w_abs2;
                  r_neg_quo <= signed_i & (opdata1_i[31] ^ opdata2_i[31]);
                  r_neg_rem <= signed_i & opdata1_i[31];
                  r_cnt     <= '0;
               end
            end
            S_BYZERO: begin
               if (w_state_next == S_DONE) begin
                  r_ready   <= 1'b1;
                  r_hilo_we <= 1'b1;
                  r_hi      <= '0;
                  r_lo      <= '0;
               end
            end
            S_RUN: begin
               if (!annul_i) begin
                  r_work <= w_work_next;
                  r_cnt  <= r_cnt + 6'd1;
                  // Sign fix-up uses the final step's result directly so the
                  // write lands in the DONE cycle.
                  if (w_state_next == S_DONE) begin
                     r_ready   <= 1'b1;
                     r_hilo_we <= 1'b1;
                     r_hi      <= w_hi_fix;
                     r_lo      <= w_lo_fix;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign ready_o   = r_ready;
   assign hilo_we_o = r_hilo_we;
   assign hi_o      = r_hi;
   assign lo_o      = r_lo;

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle 32-bit divider sequencer for the EX stage. It runs DIV/DIVU as a 32-iteration restoring divide and stalls the pipeline while busy. On completion it issues a one-cycle write of {remainder, quotient} toward the HI/LO register pair. It also honours pipeline flush (annul) at any point.

## Interface
- Parameters: none; data width fixed at `RegBus` (32), result width `DoubleRegBus` (64).
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start_i  in  1  request a division; held high by EX until ready_o.
- annul_i  in  1  flush; abort current or pending division.
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1_i  in  32  dividend; sampled only on the accepting cycle.
- opdata2_i  in  32  divisor; sampled only on the accepting cycle.
- stall_req_o  in→out  1  combinational stall request to the pipeline controller.
- ready_o  out  1  registered; high for exactly one cycle when the result is valid.
- hilo_we_o  out  1  registered; equal to ready_o; write strobe for HI/LO.
- hi_o  out  32  registered remainder; holds its value between operations.
- lo_o  out  32  registered quotient; holds its value between operations.

## Operation
- States: IDLE, BYZERO, RUN, DONE.
- IDLE
  - annul_i has priority: stay in IDLE.
  - start_i=1 and opdata2_i=0: go to BYZERO.
  - start_i=1 and opdata2_i≠0: latch |dividend|, |divisor| (absolute values only when signed_i=1), latch sign flags, clear iteration counter, go to RUN.
- RUN
  - One quotient bit per cycle, MSB first.
  - 65-bit working register {rem[32:0], quo[31:0]}: shift left 1; trial subtract divisor from the upper bits; on non-negative keep the difference and set quo LSB=1, else restore and set LSB=0.
  - After the 32nd iteration (counter 31→32) go to DONE.
- BYZERO: result forced to 64'h0; go to DONE next cycle.
- Signed fix-up, applied in the transition to DONE:
  - quotient negated when the dividend and divisor signs differ;
  - remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (signed) gives lo=0x80000000, hi=0. No trap, no special case.
- DONE
  - ready_o=1, hilo_we_o=1, hi_o/lo_o updated.
  - Next state is IDLE unconditionally.
- annul_i=1 in BYZERO or RUN: go to IDLE next edge. No ready_o or hilo_we_o is produced, and hi_o/lo_o keep their old values.
- annul_i in DONE is ignored; the write has already been issued.
- rst=1 in any state: IDLE, counter=0, ready_o=0, hilo_we_o=0, hi_o=0, lo_o=0.

## Timing
- stall_req_o=1 in each of these cases:
  - state IDLE with start_i=1 and annul_i=0;
  - state BYZERO;
  - state RUN with annul_i=0.
- stall_req_o=0 in DONE and otherwise.
- Latency, with cycle 0 = first cycle start_i is high in IDLE:
  - divisor ≠ 0: RUN in cycles 1–32, DONE (ready_o=1) in cycle 33.
  - divisor = 0: BYZERO in cycle 1, DONE in cycle 2.
- Handshake: EX drops start_i in the cycle ready_o is high, because the pipeline advances that cycle. If start_i is still high in the following IDLE cycle, a new division is accepted with freshly sampled operands. This is legal back-to-back issue.
- Operand changes after the accepting cycle have no effect.
- ready_o and hilo_we_o never assert in consecutive cycles. Minimum spacing is 3 cycles (by-zero case).

## Test plan
- Unsigned: opdata1=0xFFFFFFFF, opdata2=0x1, signed_i=0 → ready_o in cycle 33; lo_o=0xFFFFFFFF, hi_o=0; stall_req_o high cycles 0–32, low in cycle 33.
- Signed: opdata1=0xFFFFFFF9 (−7), opdata2=0x2 → lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. Also 100/−7 → lo_o=0xFFFFFFF2, hi_o=0x2.
- Divide by zero: opdata1=0x1234, opdata2=0 → ready_o and hilo_we_o in cycle 2; hi_o=lo_o=0.
- Annul: start 50/3, then assert annul_i in cycle 10 → IDLE in cycle 11; no ready_o; hi_o/lo_o retain the prior result; stall_req_o low from cycle 10.
- Reset mid-RUN: rst=1 in cycle 20 → next cycle all outputs 0 and state IDLE. A subsequent 9/3 gives lo_o=3, hi_o=0 with full 33-cycle latency.
- Back-to-back: hold start_i high through ready_o with new operands 0x80000000/0xFFFFFFFF signed → second ready_o 34 cycles after the first; lo_o=0x80000000, hi_o=0.
